// File: rtl/otter_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// otter_mem_port_arbiter
//
// Round-robin arbiter that shares one 32-bit memory/peripheral port among
// four requesters (0 = IF fetch, 1 = MEM stage, 2 = debug, 3 = DMA). It drives
// the 2-bit select of the request-data mux in front of the port and holds each
// grant until the port reports completion, then rotates priority.
//
// Optional feature: define ARB_TIMEOUT_EN to add a busy-cycle watchdog that
// force-releases a grant after TIMEOUT_CYCLES BUSY cycles without mem_done.
//
// Parameters:
//   TIMEOUT_CYCLES  BUSY cycles before forced release (ARB_TIMEOUT_EN), 2..255
//
// Ports:
//   CLK         in   1  system clock, rising edge
//   RST         in   1  asynchronous reset, active-high
//   req         in   4  per-requester request level, bit i = requester i
//   mem_done    in   1  port completion pulse, meaningful only while BUSY
//   gnt         out  4  one-hot grant, 0 when idle
//   sel         out  2  index of granted requester (mux select)
//   mem_start   out  1  pulse on the first cycle of each grant
//   busy        out  1  high while a grant is active
//   timeout     out  1  pulse on the first cycle after a forced release
//   timeout_id  out  2  index of the last timed-out requester
// -----------------------------------------------------------------------------
module otter_mem_port_arbiter #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] req,
  input  logic       mem_done,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       mem_start,
  output logic       busy,
  output logic       timeout,
  output logic [1:0] timeout_id
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // Elaboration-time legality check on the watchdog length.
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("otter_mem_port_arbiter: TIMEOUT_CYCLES must be in 2..255");
  end

  state_t     state_q, state_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] sel_q, sel_d;
  logic       mem_start_q, mem_start_d;
  logic       busy_q, busy_d;
  logic [1:0] ptr_q, ptr_d;
  logic       timeout_q, timeout_d;
  logic [1:0] timeout_id_q, timeout_id_d;

  logic       grant_s;     // a new grant is issued this cycle
  logic       to_hit_s;    // watchdog forces release this cycle
  logic [1:0] arb_ptr_s;   // priority pointer used for this cycle's scan
  logic       win_found_s;
  logic [1:0] win_idx_s;

  // Scan req starting just after ptr, ascending with wrap; first set bit wins.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 1; k <= 4; k++) begin
      idx = p + 2'(k);
      if (r[idx] && !res[2]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Index to one-hot grant vector.
  function automatic logic [3:0] to_onehot(input logic [1:0] idx);
    logic [3:0] oh;
    case (idx)
      2'd0:    oh = 4'b0001;
      2'd1:    oh = 4'b0010;
      2'd2:    oh = 4'b0100;
      2'd3:    oh = 4'b1000;
      default: oh = 4'b0000;
    endcase
    return oh;
  endfunction

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] cnt_q, cnt_d;

  // Watchdog fires on the TIMEOUT_CYCLES-th BUSY cycle unless mem_done wins.
  always_comb begin
    to_hit_s = (state_q == ST_BUSY) && (cnt_q == TO_LAST) && !mem_done;
  end

  // Busy-cycle counter: cleared by each new grant, advanced while BUSY.
  always_comb begin
    cnt_d = cnt_q;
    if (grant_s) begin
      cnt_d = 8'd0;
    end else if (state_q == ST_BUSY) begin
      cnt_d = cnt_q + 8'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Watchdog counter register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  // No watchdog: a grant is held until mem_done.
  always_comb begin
    to_hit_s = 1'b0;
  end
`endif

  // On release the just-served requester becomes the pointer, so the scan
  // for a back-to-back grant must already use sel instead of the old ptr.
  always_comb begin
    if (state_q == ST_BUSY) begin
      arb_ptr_s = sel_q;
    end else begin
      arb_ptr_s = ptr_q;
    end
    {win_found_s, win_idx_s} = rr_pick(req, arb_ptr_s);
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    sel_d        = sel_q;
    busy_d       = busy_q;
    ptr_d        = ptr_q;
    mem_start_d  = 1'b0;
    timeout_d    = 1'b0;
    timeout_id_d = timeout_id_q;
    grant_s      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (win_found_s) begin
          grant_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (mem_done || to_hit_s) begin
          ptr_d     = sel_q;
          timeout_d = to_hit_s;
          if (to_hit_s) begin
            timeout_id_d = sel_q;
          end else begin
            timeout_id_d = timeout_id_q;
          end
          if (win_found_s) begin
            grant_s = 1'b1;
          end else begin
            state_d = ST_IDLE;
            gnt_d   = 4'b0000;
            busy_d  = 1'b0;
          end
        end else begin
          state_d = ST_BUSY;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = 4'b0000;
        busy_d  = 1'b0;
      end
    endcase

    if (grant_s) begin
      state_d     = ST_BUSY;
      gnt_d       = to_onehot(win_idx_s);
      sel_d       = win_idx_s;
      busy_d      = 1'b1;
      mem_start_d = 1'b1;
    end else begin
      mem_start_d = 1'b0;
    end
  end

  // State and output registers; reset pointer 3 makes requester 0 win first.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      gnt_q        <= 4'b0000;
      sel_q        <= 2'd0;
      mem_start_q  <= 1'b0;
      busy_q       <= 1'b0;
      ptr_q        <= 2'd3;
      timeout_q    <= 1'b0;
      timeout_id_q <= 2'd0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      sel_q        <= sel_d;
      mem_start_q  <= mem_start_d;
      busy_q       <= busy_d;
      ptr_q        <= ptr_d;
      timeout_q    <= timeout_d;
      timeout_id_q <= timeout_id_d;
    end
  end

  assign gnt        = gnt_q;
  assign sel        = sel_q;
  assign mem_start  = mem_start_q;
  assign busy       = busy_q;
  assign timeout    = timeout_q;
  assign timeout_id = timeout_id_q;

endmodule
